psum_serializer: RTL

- Sits directly downstream of the core's `out` port.
- Captures each col-wide partial-sum vector into a small vector FIFO, then drains it one column per cycle over a valid/ready stream.
- Accumulates the per-vector sum of absolute values across the vector's columns. This sum is the denominator the later normalisation/softmax stage needs.
- Decouples the systolic array from a slower consumer without stalling `inst` sequencing until the FIFO fills.

---
 rtl/psum_pkg.sv | 23 ++
 rtl/psum_serializer_if.sv | 24 ++
 rtl/psum_vec_fifo.sv | 58 +++++
 rtl/psum_serializer.sv | 71 +++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared constants, psum types and the absolute-value helper for the psum serializer.
package psum_pkg;

    localparam int unsigned COL     = 8;
    localparam int unsigned BW      = 4;
    localparam int unsigned BW_PSUM = 2 * BW + 3;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned COL_W   = $clog2(COL);
    localparam int unsigned ABS_W   = BW_PSUM + COL_W;
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    typedef logic signed [BW_PSUM-1:0] psum_t;

    // Column c occupies bits [BW_PSUM*(c+1)-1 : BW_PSUM*c].
    typedef psum_t [COL-1:0] psum_vec_t;

    // Unsigned magnitude; the most negative psum maps to 2^(BW_PSUM-1), which still fits.
    function automatic logic [BW_PSUM-1:0] abs_psum(input psum_t p);
        return p[BW_PSUM-1] ? BW_PSUM'(-p) : BW_PSUM'(p);
    endfunction

endpackage

// File: rtl/psum_serializer_if.sv
// Capture-side vector handshake and drain-side column stream of the psum serializer.
interface psum_serializer_if
    import psum_pkg::*;
();
    psum_vec_t          psum_in;
    logic               psum_valid;
    logic               psum_ready;
    psum_t              ser_out;
    logic [COL_W-1:0]   ser_col;
    logic               ser_last;
    logic               ser_valid;
    logic               ser_ready;
    logic [ABS_W-1:0]   abs_sum;

    modport master (
        output psum_in, psum_valid, ser_ready,
        input  psum_ready, ser_out, ser_col, ser_last, ser_valid, abs_sum
    );

    modport slave (
        input  psum_in, psum_valid, ser_ready,
        output psum_ready, ser_out, ser_col, ser_last, ser_valid, abs_sum
    );
endinterface

// File: rtl/psum_vec_fifo.sv
// Register FIFO of whole psum vectors; not_full is registered and derived only from the occupancy.
module psum_vec_fifo
    import psum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  psum_vec_t        push_data,
    output psum_vec_t        head,
    output logic [CNT_W-1:0] count,
    output logic             not_full
);

    psum_vec_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_n;
    logic [CNT_W-1:0] count_q, count_n;
    logic             not_full_q, not_full_n;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        count_n  = count_q;
        if (push) wr_ptr_n = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_n = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_n = count_q + CNT_W'(1);
            2'b01:   count_n = count_q - CNT_W'(1);
            default: count_n = count_q;
        endcase
        not_full_n = (count_n != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_n;
            rd_ptr_q   <= rd_ptr_n;
            count_q    <= count_n;
            not_full_q <= not_full_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr_q] <= push_data;
    end

    assign head     = mem[rd_ptr_q];
    assign count    = count_q;
    assign not_full = not_full_q;

endmodule

// File: rtl/psum_serializer.sv
// Buffers psum vectors and drains them one column per beat, accumulating the vector's sum of |psum|.
module psum_serializer
    import psum_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    psum_serializer_if.slave   bus
);

    psum_vec_t        head;
    logic [CNT_W-1:0] count;
    logic             not_full;
    logic             push, pop, beat, at_last, valid;
    psum_t            cur;
    logic [ABS_W-1:0] cur_abs;
    logic [COL_W-1:0] col_idx_q, col_idx_n;
    logic [ABS_W-1:0] acc_q, acc_n;

    psum_vec_fifo u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (bus.psum_in),
        .head      (head),
        .count     (count),
        .not_full  (not_full)
    );

    assign push    = bus.psum_valid & not_full;
    assign valid   = (count != '0);
    assign cur     = head[col_idx_q];
    assign cur_abs = ABS_W'(abs_psum(cur));
    assign at_last = (col_idx_q == COL_W'(COL - 1));
    assign beat    = valid & bus.ser_ready;

    // Column walk: the last beat of a vector pops it and restarts the accumulation.
    always_comb begin
        col_idx_n = col_idx_q;
        acc_n     = acc_q;
        pop       = 1'b0;
        if (beat) begin
            if (at_last) begin
                col_idx_n = '0;
                acc_n     = '0;
                pop       = 1'b1;
            end else begin
                col_idx_n = col_idx_q + COL_W'(1);
                acc_n     = acc_q + cur_abs;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col_idx_q <= '0;
            acc_q     <= '0;
        end else begin
            col_idx_q <= col_idx_n;
            acc_q     <= acc_n;
        end
    end

    assign bus.psum_ready = not_full;
    assign bus.ser_valid  = valid;
    assign bus.ser_out    = cur;
    assign bus.ser_col    = col_idx_q;
    assign bus.ser_last   = at_last;
    assign bus.abs_sum    = (valid && at_last) ? (acc_q + cur_abs) : '0;

endmodule
